module_regfile_store: RTL and testbench

//  Register file and DISPLAY_STORE stage of the mini CPU; sits around the ALU.
//  - Supplies operands v1ULA/v2ULA in DECODE.
//  - Writes the ALU result back in DISPLAY_STORE.
//  - Sweeps the file to zero on CLEAR and latches the display value on DISPLAY.

---
 rtl/module_regfile_store.sv | 162 ++++++++++++++++
 tb/tb_module_regfile_store.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/module_regfile_store.sv
// ============================================================================
// Module      : module_regfile_store
// Description : Mini-CPU register file with operand read in DECODE and the
//               DISPLAY_STORE sequencer (write-back, CLEAR sweep, DISPLAY).
//               Optional macro REGFILE_ZERO_R0_EN makes R0 a hard-wired zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module module_regfile_store #(
  parameter int NREGS = 16,
  parameter int AW    = 4,
  parameter int W     = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    stateCPU,
  input  logic [2:0]    opcode,
  input  logic [AW-1:0] regDest,
  input  logic [AW-1:0] regSrc1,
  input  logic [AW-1:0] regSrc2,
  input  logic [W-1:0]  valorGuardarULA,
  input  logic          calculated,
  output logic [W-1:0]  v1ULA,
  output logic [W-1:0]  v2ULA,
  output logic [W-1:0]  valorDisplay,
  output logic          displayValid,
  output logic          busy,
  output logic          stored
);

  localparam logic [2:0]    c_CPU_DECODE = 3'd2;
  localparam logic [2:0]    c_CPU_DS     = 3'd4;
  localparam logic [2:0]    c_OP_CLEAR   = 3'd6;
  localparam logic [2:0]    c_OP_DISPLAY = 3'd7;
  localparam logic [AW-1:0] c_CNT_LAST   = AW'(NREGS - 1);
  localparam logic [AW-1:0] c_CNT_ONE    = AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_SWEEP = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic          r_pending;
  logic [W-1:0]  r_regs [NREGS];

  logic          w_in_ds;
  logic [W-1:0]  w_rd1;
  logic [W-1:0]  w_rd2;
  logic          w_dest_blocked;
  logic          w_wr_en;
  logic [AW-1:0] w_wr_addr;
  logic [W-1:0]  w_wr_data;

  assign w_in_ds = (stateCPU == c_CPU_DS);

`ifdef REGFILE_ZERO_R0_EN
  assign w_rd1          = (regSrc1 == '0) ? '0 : r_regs[regSrc1];
  assign w_rd2          = (regSrc2 == '0) ? '0 : r_regs[regSrc2];
  assign w_dest_blocked = (regDest == '0);
`else
  assign w_rd1          = r_regs[regSrc1];
  assign w_rd2          = r_regs[regSrc2];
  assign w_dest_blocked = 1'b0;
`endif

  // Single write port shared by ALU write-back and the CLEAR sweep.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = regDest;
    w_wr_data = valorGuardarULA;
    if (r_state == ST_WRITE && w_in_ds && r_pending && !w_dest_blocked) begin
      w_wr_en = 1'b1;
    end else if (r_state == ST_SWEEP) begin
      w_wr_en   = 1'b1;
      w_wr_addr = r_cnt;
      w_wr_data = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[w_wr_addr] <= w_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1ULA <= '0;
      v2ULA <= '0;
    end else if (stateCPU == c_CPU_DECODE) begin
      v1ULA <= w_rd1;
      v2ULA <= w_rd2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_pending    <= 1'b0;
      busy         <= 1'b0;
      stored       <= 1'b0;
      valorDisplay <= '0;
      displayValid <= 1'b0;
    end else begin
      stored <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_in_ds) begin
            if (opcode == c_OP_CLEAR) begin
              r_cnt   <= '0;
              busy    <= 1'b1;
              r_state <= ST_SWEEP;
            end else if (opcode == c_OP_DISPLAY) begin
              valorDisplay <= w_rd1;
              displayValid <= 1'b1;
              stored       <= 1'b1;
              r_state      <= ST_DONE;
            end else begin
              r_state <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (w_in_ds) begin
            r_pending <= 1'b0;
            stored    <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_SWEEP: begin
          // The sweep runs to completion regardless of stateCPU.
          r_cnt <= r_cnt + c_CNT_ONE;
          if (r_cnt == c_CNT_LAST) begin
            busy         <= 1'b0;
            valorDisplay <= '0;
            displayValid <= 1'b0;
            r_pending    <= 1'b0;
            stored       <= 1'b1;
            r_state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!w_in_ds) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
      // A fresh ALU result in the same cycle outranks the clear above.
      if (calculated) r_pending <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_module_regfile_store.sv
// ============================================================================
// Module      : tb_module_regfile_store
// Description : Self-checking bench for module_regfile_store against a
//               transaction-level model of the register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_module_regfile_store;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  stateCPU = 3'd0;
  logic [2:0]  opcode = 3'd0;
  logic [3:0]  regDest = 4'd0;
  logic [3:0]  regSrc1 = 4'd0;
  logic [3:0]  regSrc2 = 4'd0;
  logic [15:0] valorGuardarULA = 16'd0;
  logic        calculated = 1'b0;
  logic [15:0] v1ULA, v2ULA, valorDisplay;
  logic        displayValid, busy, stored;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_regs [16];
  logic        m_pend;
  logic [15:0] m_disp;
  logic        m_valid;

  module_regfile_store dut (
    .clk(clk), .rst(rst), .stateCPU(stateCPU), .opcode(opcode),
    .regDest(regDest), .regSrc1(regSrc1), .regSrc2(regSrc2),
    .valorGuardarULA(valorGuardarULA), .calculated(calculated),
    .v1ULA(v1ULA), .v2ULA(v2ULA), .valorDisplay(valorDisplay),
    .displayValid(displayValid), .busy(busy), .stored(stored)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_read(input logic [3:0] a);
`ifdef REGFILE_ZERO_R0_EN
    if (a == 4'd0) return 16'h0000;
`endif
    return m_regs[a];
  endfunction

  function automatic logic m_writable(input logic [3:0] a);
`ifdef REGFILE_ZERO_R0_EN
    return a != 4'd0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic m_zero_all();
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
    m_pend = 1'b0;
    m_disp = 16'h0000;
    m_valid = 1'b0;
  endtask

  task automatic calc();
    stateCPU = 3'd3;
    calculated = 1'b1;
    step();
    calculated = 1'b0;
    m_pend = 1'b1;
  endtask

  task automatic decode(input logic [3:0] s1, input logic [3:0] s2);
    logic [15:0] e1;
    e1 = m_read(s1);
    stateCPU = 3'd2;
    regSrc1 = s1;
    regSrc2 = s2;
    step();
    chk("v1ULA", {16'h0, v1ULA}, {16'h0, e1});
    chk("v2ULA", {16'h0, v2ULA}, {16'h0, m_read(s2)});
    stateCPU = 3'd1;
    regSrc1 = ~s1;
    step();
    chk("v1ULA_hold", {16'h0, v1ULA}, {16'h0, e1});
  endtask

  task automatic scan_all();
    for (int i = 0; i < 8; i++) decode(4'(i), 4'(i + 8));
  endtask

  // One DISPLAY_STORE visit: stored must pulse once, at the point the op finishes.
  task automatic ds_txn(input logic [2:0] op, input logic [3:0] dest, input logic [3:0] s1,
                        input logic [15:0] val, input int hold);
    int exp_at, first, n_st, n_busy;
    exp_at = (op == 3'd7) ? 1 : (op == 3'd6) ? 17 : 2;
    first = 0; n_st = 0; n_busy = 0;
    stateCPU = 3'd4;
    opcode = op;
    regDest = dest;
    regSrc1 = s1;
    valorGuardarULA = val;
    for (int c = 1; c <= exp_at + hold; c++) begin
      step();
      if (stored === 1'b1) begin
        n_st++;
        if (first == 0) first = c;
      end
      if (busy === 1'b1) n_busy++;
    end
    chk("stored_count", n_st, 1);
    chk("stored_cycle", first, exp_at);
    if (op == 3'd6) chk("busy_cycles", n_busy, 16);
    if (op == 3'd6) m_zero_all();
    else if (op == 3'd7) begin
      m_disp = m_read(s1);
      m_valid = 1'b1;
    end else begin
      if (m_pend && m_writable(dest)) m_regs[dest] = val;
      m_pend = 1'b0;
    end
    chk("valorDisplay", {16'h0, valorDisplay}, {16'h0, m_disp});
    chk("displayValid", {31'h0, displayValid}, {31'h0, m_valid});
    stateCPU = 3'd1;
    step();
  endtask

  initial begin
    logic [3:0]  d;
    logic [15:0] v;
    int          sel;
    int          n_st;

    m_zero_all();
    step();
    step();
    chk("rst_v1", {16'h0, v1ULA}, 32'h0);
    chk("rst_v2", {16'h0, v2ULA}, 32'h0);
    chk("rst_disp", {16'h0, valorDisplay}, 32'h0);
    chk("rst_flags", {29'h0, displayValid, busy, stored}, 32'h0);
    rst = 1'b0;
    stateCPU = 3'd1;
    step();

    // LOAD into R3, then read it back
    calc();
    ds_txn(3'd0, 4'd3, 4'd0, 16'h0025, 0);
    decode(4'd3, 4'd0);

    // ADD held in DISPLAY_STORE for 5 extra cycles, then re-entry
    calc();
    ds_txn(3'd1, 4'd2, 4'd0, 16'h0BEE, 5);
    decode(4'd2, 4'd3);
    calc();
    ds_txn(3'd1, 4'd2, 4'd0, 16'h0C01, 0);
    decode(4'd2, 4'd3);

    // Store without a fresh calculation is dropped
    ds_txn(3'd3, 4'd2, 4'd0, 16'hDEAD, 0);
    decode(4'd2, 4'd2);

    // DISPLAY then CLEAR
    calc();
    ds_txn(3'd0, 4'd5, 4'd0, 16'h1234, 0);
    ds_txn(3'd7, 4'd0, 4'd5, 16'h0000, 2);
    chk("disp_1234", {16'h0, valorDisplay}, 32'h1234);
    ds_txn(3'd6, 4'd0, 4'd0, 16'h0000, 0);
    scan_all();

    // R0 behaviour
    calc();
    ds_txn(3'd0, 4'd0, 4'd0, 16'h00FF, 0);
    decode(4'd0, 4'd0);

    // Randomized mix
    for (int it = 0; it < 60; it++) begin
      sel = $urandom_range(0, 5);
      d = 4'($urandom_range(0, 15));
      v = 16'($urandom);
      case (sel)
        0, 1: begin
          calc();
          ds_txn(3'($urandom_range(0, 5)), d, 4'd0, v, $urandom_range(0, 3));
        end
        2: ds_txn(3'($urandom_range(0, 5)), d, 4'd0, v, 0);
        3: decode(d, 4'($urandom_range(0, 15)));
        4: ds_txn(3'd7, 4'd0, d, 16'h0000, $urandom_range(0, 2));
        default: begin
          if ($urandom_range(0, 5) == 0) ds_txn(3'd6, 4'd0, 4'd0, 16'h0000, 0);
          else decode(d, ~d);
        end
      endcase
    end
    scan_all();

    // Asynchronous reset in the middle of a CLEAR sweep
    for (int i = 0; i < 16; i++) begin
      calc();
      ds_txn(3'd0, 4'(i), 4'd0, 16'hA500 + 16'(i), 0);
    end
    ds_txn(3'd7, 4'd0, 4'd9, 16'h0000, 0);
    n_st = 0;
    stateCPU = 3'd4;
    opcode = 3'd6;
    for (int c = 0; c < 8; c++) begin
      step();
      if (stored === 1'b1) n_st++;
    end
    chk("busy_mid_sweep", {31'h0, busy}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_busy", {31'h0, busy}, 32'h0);
    chk("rst_async_valid", {31'h0, displayValid}, 32'h0);
    chk("rst_async_disp", {16'h0, valorDisplay}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    stateCPU = 3'd1;
    step();
    if (stored === 1'b1) n_st++;
    chk("no_stored_on_rst", n_st, 0);
    m_zero_all();
    scan_all();
    calc();
    ds_txn(3'd0, 4'd7, 4'd0, 16'h7777, 0);
    decode(4'd7, 4'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
